// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-port memory arbiter between instruction fetch (IFU) and load/store (LSU)
//
// Purpose: shares one memory request/response port between the IFU and the LSU.
//          One transaction is outstanding at a time: a winner is accepted in IDLE,
//          its request is forwarded in REQ, and the response is routed back to it
//          in RESP before the next request can be accepted.
//
// Ports:
//   clk, rst                                  clock (rising edge), async active-high reset
//   ifu_req_valid/ready, ifu_addr             IFU read request
//   ifu_resp_valid/ready, ifu_rdata           IFU read response
//   lsu_req_valid/ready, lsu_addr, lsu_wen,
//   lsu_wdata, lsu_wmask                      LSU load/store request
//   lsu_resp_valid/ready, lsu_rdata           LSU load data / store ack
//   mem_req_valid/ready, mem_addr, mem_wen,
//   mem_wdata, mem_wmask                      forwarded request to the memory bridge
//   mem_resp_valid/ready, mem_rdata           response from the memory bridge
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   - on a tie the master that did not win last time is granted
//   undefined - fixed priority, the LSU wins every tie

module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Owner / last_grant encoding: 0 = IFU, 1 = LSU.
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    logic [1:0]          state_q, state_d;
    logic                own_q, own_d;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;

    logic grant_lsu;
    logic is_idle;
    logic in_req;
    logic in_resp;
    logic owner_resp_ready;

    // Tie-break between the two masters; only meaningful when a valid is present.
`ifdef ARB_ROUND_ROBIN_EN
    assign grant_lsu = lsu_req_valid & (~ifu_req_valid | (last_grant_q == OWN_IFU));
`else
    assign grant_lsu = lsu_req_valid;
`endif

    // Readies are masked by rst so they read 0 while reset is held even though
    // IDLE would otherwise pass the incoming valids straight through.
    assign is_idle = (state_q == S_IDLE) & ~rst;
    assign in_req  = (state_q == S_REQ);
    assign in_resp = (state_q == S_RESP);

    assign lsu_req_ready = is_idle & grant_lsu;
    assign ifu_req_ready = is_idle & ifu_req_valid & ~grant_lsu;

    assign owner_resp_ready = (own_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

    assign mem_req_valid  = in_req;
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign mem_resp_ready = in_resp & owner_resp_ready;

    // Response is passed through combinationally to the owner only.
    assign ifu_resp_valid = in_resp & (own_q == OWN_IFU) & mem_resp_valid;
    assign lsu_resp_valid = in_resp & (own_q == OWN_LSU) & mem_resp_valid;
    assign ifu_rdata      = (in_resp & (own_q == OWN_IFU)) ? mem_rdata : '0;
    assign lsu_rdata      = (in_resp & (own_q == OWN_LSU)) ? mem_rdata : '0;

    always_comb begin
        state_d      = state_q;
        own_d        = own_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;

        case (state_q)
            S_IDLE: begin
                if (lsu_req_ready) begin
                    own_d   = OWN_LSU;
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                    state_d = S_REQ;
                end else if (ifu_req_ready) begin
                    // Fetches are always reads.
                    own_d   = OWN_IFU;
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (mem_resp_valid & owner_resp_ready) begin
                    last_grant_d = own_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            own_q        <= OWN_IFU;
            last_grant_q <= OWN_LSU;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else begin
            state_q      <= state_d;
            own_q        <= own_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
        end
    end

endmodule
